// File: rtl/multi_operand_sched.sv
// multi_operand_sched: accumulates groups of NUM_OPS unsigned operands and reduces them
// with one shared 4-operand adder. The sum appears 3 edges after the last operand is accepted.
// Backpressure: in_ready is low from the end of a group until the sum is taken; DONE holds for out_ready.
// Optional SCHED_FLUSH_EN macro: adds in_last, so that short groups (unfilled slots are zero) are allowed.
module multi_operand_sched #(
  parameter int OP_W    = 7,
  parameter int NUM_OPS = 8   // only 8 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_data,
`ifdef SCHED_FLUSH_EN
  input  logic              in_last,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W+2:0]   out_sum,
  output logic              busy
);

  localparam int SUM_W = OP_W + 3;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    RED0  = 3'd1,
    RED1  = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        op_cnt;
  logic [OP_W-1:0]   slot [NUM_OPS];
  logic [SUM_W-1:0]  pa;
  logic [SUM_W-1:0]  pb;
  logic [SUM_W-1:0]  add_a;
  logic [SUM_W-1:0]  add_b;
  logic [SUM_W-1:0]  add_c;
  logic [SUM_W-1:0]  add_d;
  logic [SUM_W-1:0]  add_sum;
  logic              last_flag;
  logic              last_slot;
  logic              accept;
  logic              group_end;

`ifdef SCHED_FLUSH_EN
  assign last_flag = in_last;
`else
  assign last_flag = 1'b0;
`endif

  // Accept and group-end qualifiers; derived from state directly, not from in_ready,
  // which keeps the FSM's combinational block free of feedback.
  always_comb begin
    last_slot = (op_cnt == 3'(NUM_OPS - 1));
    accept    = in_valid && (state == LOAD);
    group_end = accept && (last_slot || last_flag);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && (last_slot || last_flag)) begin
          state_nxt = RED0;
        end
      end
      RED0:  state_nxt = RED1;
      RED1:  state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Operand mux for the single shared adder: the two halves, then the two partials.
  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = '0;
    add_d = '0;
    case (state)
      RED0: begin
        add_a = SUM_W'(slot[0]);
        add_b = SUM_W'(slot[1]);
        add_c = SUM_W'(slot[2]);
        add_d = SUM_W'(slot[3]);
      end
      RED1: begin
        add_a = SUM_W'(slot[4]);
        add_b = SUM_W'(slot[5]);
        add_c = SUM_W'(slot[6]);
        add_d = SUM_W'(slot[7]);
      end
      FINAL: begin
        add_a = pa;
        add_b = pb;
      end
      default: ;
    endcase
    add_sum = add_a + add_b + add_c + add_d;
  end

  // Operand capture. A flushed group zeroes the slots above the last one written,
  // so that no operand from an earlier group leaks into the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        slot[i] <= '0;
      end
    end else if (accept) begin
      slot[op_cnt] <= in_data;
      if (last_flag) begin
        for (int i = 0; i < NUM_OPS; i++) begin
          if (3'(i) > op_cnt) begin
            slot[i] <= '0;
          end
        end
      end
      if (group_end) begin
        op_cnt <= '0;
      end else begin
        op_cnt <= op_cnt + 3'd1;
      end
    end
  end

  // Reduction registers: each is written only in its own state, so out_sum stays stable in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa      <= '0;
      pb      <= '0;
      out_sum <= '0;
    end else begin
      case (state)
        RED0:    pa      <= add_sum;
        RED1:    pb      <= add_sum;
        FINAL:   out_sum <= add_sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_operand_sched.sv
// tb_multi_operand_sched: random and directed groups are checked against a sum-of-operands model.
// The timing model is: out_valid is asserted exactly 3 edges after the accept of the last operand.
// out_sum must be held while out_ready is low, and reset is applied asynchronously mid-flight.
module tb_multi_operand_sched;
  localparam int OP_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [OP_W-1:0]   in_data = '0;
`ifdef SCHED_FLUSH_EN
  logic              in_last = 1'b0;
`endif
  logic              in_ready;
  logic              out_valid;
  logic              busy;
  logic [OP_W+2:0]   out_sum;

  int n_cmp = 0;
  int n_err = 0;
  logic [OP_W-1:0] grp [8];
  int gaps [8];

  always #5 clk = ~clk;

  multi_operand_sched #(.OP_W(OP_W), .NUM_OPS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SCHED_FLUSH_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_sum"},   int'(out_sum),   0);
    chk({tag, "_in_ready"},  int'(in_ready),  1);
    chk({tag, "_busy"},      int'(busy),      0);
  endtask

  // Present one operand after `gap` idle cycles (junk on in_data) and complete its handshake.
  task automatic push(input logic [OP_W-1:0] d, input int gap, input bit last);
    int w;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = OP_W'($urandom);
    end
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
`ifdef SCHED_FLUSH_EN
    in_last  = last;
`else
    if (last) $fatal(1, "FAIL push: short group needs SCHED_FLUSH_EN");
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = OP_W'($urandom);
`ifdef SCHED_FLUSH_EN
    in_last  = 1'b0;
`endif
  endtask

  // Send grp[0..n-1] with gaps[], then check the latency, the hold behaviour and the handshake.
  task automatic run_group(input string tag, input int n, input int hold, input bit junk);
    int exp;
    exp = 0;
    for (int i = 0; i < n; i++) begin
      exp += int'(grp[i]);
      push(grp[i], gaps[i], (n < 8) && (i == n - 1));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_lat_vld"}, int'(out_valid), (k == 3) ? 1 : 0);
      if (k < 3) chk({tag, "_red_rdy"}, int'(in_ready), 0);
      if (junk && k < 3) begin
        in_valid = 1'b1;
        in_data  = OP_W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk({tag, "_sum"}, int'(out_sum), exp);
    chk({tag, "_busy"}, int'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, int'(out_valid), 1);
      chk({tag, "_hold_sum"}, int'(out_sum), exp);
      chk({tag, "_hold_rdy"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_post_vld"}, int'(out_valid), 0);
    chk({tag, "_post_rdy"}, int'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  task automatic fill(input logic [OP_W-1:0] v);
    for (int i = 0; i < 8; i++) begin
      grp[i]  = v;
      gaps[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Maximum operands back-to-back: 8 x 127 = 1016.
    fill(7'd127);
    run_group("max", 8, 0, 0);

    // Operands 1..8 with a 2-cycle in_valid gap before the 4th operand.
    for (int i = 0; i < 8; i++) begin
      grp[i]  = OP_W'(i + 1);
      gaps[i] = (i == 3) ? 2 : 0;
    end
    run_group("gap", 8, 0, 1);

    // Consumer stalls 5 cycles, then a follow-up group.
    fill(7'd5);
    run_group("stall", 8, 5, 0);
    fill(7'd1);
    run_group("after_stall", 8, 0, 0);

    // Reset while in RED1: the outputs must drop immediately, without a clock edge.
    fill(7'd9);
    for (int i = 0; i < 8; i++) push(grp[i], 0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("red1_rst");
    @(negedge clk);
    rst_n = 1'b1;
    fill(7'd2);
    run_group("post_rst", 8, 0, 0);

    // Reset with a partially loaded group: those operands must be discarded.
    for (int i = 0; i < 3; i++) push(7'd100, 0, 1'b0);
    do_reset();
    fill(7'd3);
    run_group("partial_rst", 8, 0, 0);

`ifdef SCHED_FLUSH_EN
    // Short group 10, 20, 30 (last), then a full group to expose stale slots.
    fill(7'd0);
    grp[0] = 7'd10;
    grp[1] = 7'd20;
    grp[2] = 7'd30;
    run_group("flush", 3, 0, 0);
    fill(7'd1);
    run_group("post_flush", 8, 0, 0);
`endif

    // Random groups.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = 8;
`ifdef SCHED_FLUSH_EN
      n = $urandom_range(8, 1);
`endif
      for (int i = 0; i < 8; i++) begin
        grp[i]  = OP_W'($urandom);
        gaps[i] = $urandom_range(2, 0);
      end
      run_group("rand", n, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_operand_sched.md
MULTI_OPERAND_SCHED -- requirements
Module: multi_operand_sched

Interface
REQ-001 The block SHALL have parameter OP_W, default 7, meaning operand width in bits.
REQ-002 The block SHALL have parameter NUM_OPS, default 8, meaning operands per group; only the value 8 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand on in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 The block SHALL have port in_data, input, OP_W bits: an unsigned operand.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_sum holds a completed group sum.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_sum.
REQ-010 The block SHALL have port out_sum, output, OP_W+3 bits: unsigned sum of the group.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except LOAD.

Function
REQ-012 The block SHALL implement FSM states LOAD, RED0, RED1, FINAL and DONE; the reset state is LOAD.
REQ-013 In LOAD, in_ready SHALL be 1, and each in_valid&in_ready edge SHALL store in_data into operand slot op_cnt and increment op_cnt (3 bits).
REQ-014 The edge that accepts the operand for slot 7 SHALL move the FSM to RED0; op_cnt SHALL wrap to 0.
REQ-015 The block SHALL contain exactly one shared 4-operand adder, OP_W+3 bits wide, with no further adders on the sum path.
REQ-016 RED0 SHALL add slots 0-3 into partial register pa, RED1 SHALL add slots 4-7 into pb, and FINAL SHALL add pa, pb, 0, 0 into out_sum; each state lasts one cycle.
REQ-017 DONE SHALL drive out_valid=1 and hold out_sum stable until an out_valid&out_ready edge, which SHALL move the FSM to LOAD.
REQ-018 Latency SHALL be exactly 3 edges: out_valid rises on the 3rd rising edge after the edge that accepts the 8th operand.
REQ-019 in_ready SHALL be 0 in RED0, RED1, FINAL and DONE; in_data is ignored while in_ready=0.
REQ-020 Gaps in in_valid during LOAD SHALL neither lose nor duplicate operands.
REQ-021 The arithmetic SHALL be exact with no overflow; the maximum sum is 8*(2^OP_W-1), which is 1016 for OP_W=7.
REQ-022 Operand slots SHALL be transferred in order, with no reordering across groups.

Reset
REQ-023 Asserting rst_n=0 SHALL, at any time including mid-reduction, immediately force LOAD, op_cnt=0, pa=pb=0, out_sum=0, out_valid=0, in_ready=1 and busy=0.
REQ-024 Any partially loaded or in-flight group SHALL be discarded on reset, and the first operand after reset release SHALL fill slot 0.

Configuration
REQ-025 Macro SCHED_FLUSH_EN SHALL control short groups.
REQ-026 With SCHED_FLUSH_EN defined, the block SHALL add input in_last (1 bit).
REQ-027 With SCHED_FLUSH_EN defined, an accepted operand with in_last=1 SHALL end the group: unfilled slots are zero and the FSM moves to RED0.
REQ-028 With SCHED_FLUSH_EN defined, in_last on slot 7 SHALL behave as a normal 8th operand.
REQ-029 Without SCHED_FLUSH_EN, port in_last SHALL be absent and groups SHALL always contain exactly 8 operands.

Verification
REQ-030 Eight operands of 127, back-to-back with out_ready=1 -> out_valid rises 3 edges after the 8th accept, out_sum=1016, and in_ready returns to 1 the cycle after.
REQ-031 Operands 1..8, with in_valid low for 2 cycles between the 3rd and 4th operand -> out_sum=36, and no extra operand is accepted.
REQ-032 Group of 8x5 with out_ready held 0 for 5 cycles in DONE -> out_valid=1 and out_sum=40 stable throughout, in_ready=0; a following group of 8x1 gives out_sum=8.
REQ-033 rst_n pulsed low while in RED1 -> all outputs at reset values immediately; a following group of 8x2 gives out_sum=16.
REQ-034 With SCHED_FLUSH_EN defined, operands 10, 20, 30 with in_last on 30 -> out_sum=60; the next 8-operand group of 1 gives out_sum=8, showing no stale slots.
